// File: rtl/issue_fifo.sv
// issue_fifo: multi-port in-order issue queue between dispatch and issue.
// Up to ENQ_W entries enter per cycle (all-or-nothing), the oldest DEQ_W
// entries are presented with per-lane valid flags, and dequeue requests
// clamp to what is actually held. Occupancy and free counts are registered.
module issue_fifo #(
    parameter int  DEPTH  = 16,
    parameter int  ENQ_W  = 4,
    parameter int  DEQ_W  = 2,
    parameter int  DATA_W = 64,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [$clog2(ENQ_W+1)-1:0]   enq_num,
    input  logic [ENQ_W*DATA_W-1:0]      enq_data,
    output logic                         enq_ready,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_num,
    output logic [DEQ_W*DATA_W-1:0]      out_data,
    output logic [DEQ_W-1:0]             out_valid,
    output logic [CNT_W-1:0]             count,
    output logic [CNT_W-1:0]             free
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ENQ_NW = $clog2(ENQ_W + 1);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  free_q, free_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  enq_ext;
    logic [CNT_W-1:0]  deq_ext;
    logic [CNT_W-1:0]  acc_enq;
    logic [CNT_W-1:0]  eff_deq;
    logic              do_enq;

    assign enq_ext   = CNT_W'(enq_num);
    assign deq_ext   = CNT_W'(deq_num);
    // Room is judged on the registered free count only; a same-cycle
    // dequeue never makes space for the offered group.
    assign enq_ready = (enq_ext <= free_q);
    assign do_enq    = enq_ready && (enq_num != '0) && !flush && !rst;

    assign count = count_q;
    assign free  = free_q;

    // Next-state for pointers and counters; flush overrides everything.
    // Counter arithmetic stays in CNT_W bits: the true result is bounded by
    // DEPTH, so modular wrap of the intermediate cannot change it.
    always_comb begin
        acc_enq = do_enq ? enq_ext : '0;
        eff_deq = deq_ext;
        if (eff_deq > count_q) begin
            eff_deq = count_q;
        end
        if (eff_deq > CNT_W'(DEQ_W)) begin
            eff_deq = CNT_W'(DEQ_W);
        end
        head_d  = head_q + PTR_W'(eff_deq);
        tail_d  = tail_q + PTR_W'(acc_enq);
        count_d = count_q + acc_enq - eff_deq;
        free_d  = CNT_W'(DEPTH) - count_d;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            free_d  = CNT_W'(DEPTH);
        end
    end

    // Control state register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            free_q  <= CNT_W'(DEPTH);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            free_q  <= free_d;
        end
    end

    // Entry storage: accepted lanes land at consecutive slots from tail.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            if (do_enq && (ENQ_NW'(i) < enq_num)) begin
                mem_q[tail_q + PTR_W'(i)] <= enq_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read window: the oldest DEQ_W slots, zeroed where no entry is held.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            if (CNT_W'(i) < count_q) begin
                out_valid[i]                 = 1'b1;
                out_data[i*DATA_W +: DATA_W] = mem_q[head_q + PTR_W'(i)];
            end
        end
    end
endmodule

// File: tb/tb_issue_fifo.sv
// tb_issue_fifo: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_issue_fifo;
    localparam int DEPTH  = 16;
    localparam int ENQ_W  = 4;
    localparam int DEQ_W  = 2;
    localparam int DATA_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  enq_num;
    logic [31:0] enq_data;
    logic        enq_ready;
    logic [1:0]  deq_num;
    logic [15:0] out_data;
    logic [1:0]  out_valid;
    logic [4:0]  count;
    logic [4:0]  free;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of entries, oldest at index 0.
    logic [7:0] mq[$];

    always #5 clk = ~clk;

    issue_fifo #(
        .DEPTH  (DEPTH),
        .ENQ_W  (ENQ_W),
        .DEQ_W  (DEQ_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_num   (enq_num),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_num   (deq_num),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (count),
        .free      (free)
    );

    always @(posedge clk) begin
        assert (enq_num <= 3'(ENQ_W))
            else $error("FAIL enq_num_legal: got %0d required <= %0d", enq_num, ENQ_W);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [1:0]  ev;
        logic [15:0] ed;
        ev = '0;
        ed = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            if (i < mq.size()) begin
                ev[i]        = 1'b1;
                ed[i*8 +: 8] = mq[i];
            end
        end
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".free"},  32'(free),  32'(DEPTH - mq.size()));
        chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".data"},  32'(out_data),  32'(ed));
    endtask

    // One clock: drive, check enq_ready before the edge, advance the model,
    // then check the registered view after the edge.
    task automatic cycle(input logic r, input logic f, input int en,
                         input logic [31:0] ed, input int dn, input string tag);
        int eff;
        bit rdy;
        rst      = r;
        flush    = f;
        enq_num  = 3'(en);
        enq_data = ed;
        deq_num  = 2'(dn);
        #1;
        rdy = (en <= DEPTH - mq.size());
        chk({tag, ".enq_ready"}, 32'(enq_ready), 32'(rdy));
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else begin
            eff = dn;
            if (eff > mq.size()) eff = mq.size();
            if (eff > DEQ_W)     eff = DEQ_W;
            repeat (eff) void'(mq.pop_front());
            if (rdy) begin
                for (int i = 0; i < en; i++) mq.push_back(ed[i*8 +: 8]);
            end
        end
        #1;
        check_state(tag);
    endtask

    typedef struct {
        logic        r;
        logic        f;
        int          en;
        logic [31:0] ed;
        int          dn;
        logic        exp_ready;
        int          exp_count;
        logic [1:0]  exp_valid;
        logic [15:0] exp_out;
    } vec_t;

    vec_t tbl[9];
    logic [7:0] sent[$];
    logic [7:0] recv[$];

    initial begin
        int eff;
        int en;
        int guard;
        logic [31:0] d;

        rst = 1'b1; flush = 1'b0; enq_num = '0; enq_data = '0; deq_num = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        check_state("reset");
        chk("reset.out_data_zero", 32'(out_data), 32'h0);
        enq_num = 3'd4;
        #1;
        chk("reset.enq_ready4", 32'(enq_ready), 32'h1);

        //          r     f     en ed            dn rdy   cnt valid  out
        tbl[0] = '{1'b0, 1'b0, 3, 32'h00A2A1A0, 0, 1'b1, 3, 2'b11, 16'hA1A0};
        tbl[1] = '{1'b0, 1'b0, 0, 32'h0,        2, 1'b1, 1, 2'b01, 16'h00A2};
        tbl[2] = '{1'b0, 1'b0, 0, 32'h0,        2, 1'b1, 0, 2'b00, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 0, 32'h0,        2, 1'b1, 0, 2'b00, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 4, 32'hC3C2C1C0, 3, 1'b1, 4, 2'b11, 16'hC1C0};
        tbl[5] = '{1'b0, 1'b0, 4, 32'hD3D2D1D0, 3, 1'b1, 6, 2'b11, 16'hC3C2};
        tbl[6] = '{1'b0, 1'b1, 4, 32'hE3E2E1E0, 2, 1'b1, 0, 2'b00, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 4, 32'hF3F2F1F0, 0, 1'b1, 0, 2'b00, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 1, 32'h000000B0, 0, 1'b1, 1, 2'b01, 16'h00B0};

        for (int k = 0; k < 9; k++) begin
            rst = tbl[k].r; flush = tbl[k].f;
            enq_num = 3'(tbl[k].en); enq_data = tbl[k].ed; deq_num = 2'(tbl[k].dn);
            #1;
            chk($sformatf("tbl%0d.ready", k), 32'(enq_ready), 32'(tbl[k].exp_ready));
            cycle(tbl[k].r, tbl[k].f, tbl[k].en, tbl[k].ed, tbl[k].dn, $sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d.tcount", k), 32'(count), 32'(tbl[k].exp_count));
            chk($sformatf("tbl%0d.tfree", k), 32'(free), 32'(DEPTH - tbl[k].exp_count));
            chk($sformatf("tbl%0d.tvalid", k), 32'(out_valid), 32'(tbl[k].exp_valid));
            chk($sformatf("tbl%0d.tout", k), 32'(out_data), 32'(tbl[k].exp_out));
        end

        // Fill to 15, then probe the full boundary.
        cycle(1'b0, 1'b1, 0, 32'h0, 0, "fill.flush");
        cycle(1'b0, 1'b0, 4, 32'h13121110, 0, "fill.a");
        cycle(1'b0, 1'b0, 4, 32'h17161514, 0, "fill.b");
        cycle(1'b0, 1'b0, 4, 32'h1B1A1918, 0, "fill.c");
        cycle(1'b0, 1'b0, 3, 32'h001E1D1C, 0, "fill.d");
        chk("fill.count15", 32'(count), 32'd15);
        cycle(1'b0, 1'b0, 2, 32'h00002120, 2, "fill.reject");
        chk("fill.count13", 32'(count), 32'd13);
        cycle(1'b0, 1'b0, 2, 32'h00002322, 0, "fill.to15");
        cycle(1'b0, 1'b0, 1, 32'h00000024, 0, "fill.to16");
        chk("fill.count16", 32'(count), 32'd16);
        chk("fill.free0", 32'(free), 32'd0);
        cycle(1'b0, 1'b0, 1, 32'h00000025, 1, "fill.full_deq");
        chk("fill.count15b", 32'(count), 32'd15);

        // Wrap-around: the dequeued stream must equal the accepted stream.
        cycle(1'b0, 1'b1, 0, 32'h0, 0, "wrap.flush");
        for (int rnd = 0; rnd < 10; rnd++) begin
            eff = (mq.size() < DEQ_W) ? mq.size() : DEQ_W;
            for (int i = 0; i < eff; i++) recv.push_back(out_data[i*8 +: 8]);
            en = (4 <= DEPTH - mq.size()) ? 4 : 0;
            d  = $urandom();
            for (int i = 0; i < en; i++) sent.push_back(d[i*8 +: 8]);
            cycle(1'b0, 1'b0, en, d, 2, $sformatf("wrap%0d", rnd));
        end
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            eff = (mq.size() < DEQ_W) ? mq.size() : DEQ_W;
            for (int i = 0; i < eff; i++) recv.push_back(out_data[i*8 +: 8]);
            cycle(1'b0, 1'b0, 0, 32'h0, 2, "wrap.drain");
            guard++;
        end
        chk("wrap.drain_bound", 32'(guard < 40), 32'h1);
        chk("wrap.length", 32'(recv.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size() && i < recv.size(); i++) begin
            chk($sformatf("wrap.order%0d", i), 32'(recv[i]), 32'(sent[i]));
        end

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            cycle(1'(($urandom() % 64) == 0), 1'(($urandom() % 32) == 0),
                  int'($urandom_range(0, ENQ_W)), $urandom(),
                  int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
